// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-port ALU sharing controller.
package alu_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_ADDU = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_DIFF = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [2:0] OP_SHIFT_PFX = 3'b010;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the port not granted last wins.
module rr_arbiter_2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  assign grant[0] = req0 & (~req1 | last_grant);
  assign grant[1] = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters with a
// three-state accept / execute / respond sequence.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ipsel,
  input  logic [OPW-1:0]   req0_opsel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ipsel,
  input  logic [OPW-1:0]   req1_opsel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ipsel,
  output logic [OPW-1:0]   alu_opsel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ipsel_q, ipsel_d;
  logic [OPW-1:0]   opsel_q, opsel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [1:0]       grant;
  logic             owner_ready;

  rr_arbiter_2 u_arb (
    .req0       (req0_valid),
    .req1       (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Readies are masked during reset so nothing is accepted while the FSM is held.
  assign req0_ready  = ~rst & (state_q == IDLE) & grant[0];
  assign req1_ready  = ~rst & (state_q == IDLE) & grant[1];
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    ipsel_d      = ipsel_q;
    opsel_d      = opsel_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = grant[1];
          last_grant_d = grant[1];
          a_d          = grant[1] ? req1_a     : req0_a;
          b_d          = grant[1] ? req1_b     : req0_b;
          ipsel_d      = grant[1] ? req1_ipsel : req0_ipsel;
          opsel_d      = grant[1] ? req1_opsel : req0_opsel;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d     = alu_result;
        zero_d       = (alu_result == '0);
        // Only a plain add produces a meaningful carry-out.
        carry_d      = (opsel_q == OPW'(OP_ADD)) & alu_carry;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ipsel_q      <= 1'b0;
      opsel_q      <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ipsel_q      <= ipsel_d;
      opsel_q      <= opsel_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ipsel  = ipsel_q;
  assign alu_opsel  = opsel_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a small behavioural ALU.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ipsel, req1_ipsel;
  logic [4:0]  req0_opsel, req1_opsel;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic [31:0] alu_a, alu_b;
  logic        alu_ipsel;
  logic [4:0]  alu_opsel;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic [32:0] sum33;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ipsel(req0_ipsel), .req0_opsel(req0_opsel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ipsel(req1_ipsel), .req1_opsel(req1_opsel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ipsel(alu_ipsel), .alu_opsel(alu_opsel),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // Behavioural ALU: carry is the raw adder carry regardless of opcode.
  always_comb begin
    sum33     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum33[32];
    case (alu_opsel)
      5'b00000: alu_result = alu_a;
      5'b00001: alu_result = sum33[31:0];
      5'b00011: alu_result = alu_a & alu_b;
      default:  alu_result = 32'h0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_ipsel = 0; req0_opsel = 0;
    req1_a = 0; req1_b = 0; req1_ipsel = 0; req1_opsel = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("reset_result", rsp_result, 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single op on port 0: 5 + 7, non-owner ready ignored
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_opsel = 5'b00001; req0_ipsel = 1;
    rsp1_ready = 1;
    #1;
    checkOutput("t1_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("t1_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0;
    checkOutput("t1_exec_ready", 32'(req0_ready), 32'd0);
    checkOutput("t1_alu_a", alu_a, 32'd5);
    checkOutput("t1_alu_ipsel", 32'(alu_ipsel), 32'd1);
    tick();
    checkOutput("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("t1_result", rsp_result, 32'd12);
    checkOutput("t1_carry", 32'(rsp_carry), 32'd0);
    checkOutput("t1_zero", 32'(rsp_zero), 32'd0);
    tick();
    checkOutput("t1_nonowner_ignored", 32'(rsp0_valid), 32'd1);
    rsp0_ready = 1;
    tick();
    checkOutput("t1_done", 32'(rsp0_valid), 32'd0);
    rsp1_ready = 0;
    rsp0_ready = 0;

    // Port 1 alone: AND of all-ones with 1
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_opsel = 5'b00011;
    #1;
    checkOutput("and_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    tick();
    checkOutput("and_rsp1_valid", 32'(rsp1_valid), 32'd1);
    checkOutput("and_result", rsp_result, 32'd1);
    checkOutput("and_carry", 32'(rsp_carry), 32'd0);
    checkOutput("and_zero", 32'(rsp_zero), 32'd0);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // Both valid: last grant was port 1, so alternate 0,1,0,1
    req0_valid = 1; req0_a = 10; req0_b = 3; req0_opsel = 5'b00001;
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_opsel = 5'b00001;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("alt_req0_ready", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("alt_req1_ready", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      checkOutput("alt_exec_noready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
      checkOutput("alt_rsp0_valid", 32'(rsp0_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("alt_rsp1_valid", 32'(rsp1_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("alt_result", rsp_result, (k % 2 == 0) ? 32'd13 : 32'd0);
      checkOutput("alt_carry", 32'(rsp_carry), (k % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("alt_zero", 32'(rsp_zero), (k % 2 == 0) ? 32'd0 : 32'd1);
      @(posedge clk);
    end
    #1;
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick();

    // Stall: port 0 response unconsumed while port 1 waits
    req0_valid = 1; req0_a = 10; req0_b = 3; req0_opsel = 5'b00001;
    #1;
    checkOutput("stall_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 42; req1_b = 9; req1_opsel = 5'b00000;
    tick();
    rsp1_ready = 1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_req1_ready", 32'(req1_ready), 32'd0);
      checkOutput("stall_result", rsp_result, 32'd13);
      checkOutput("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      tick();
    end
    rsp1_ready = 0;
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    checkOutput("stall_release_rsp0", 32'(rsp0_valid), 32'd0);
    checkOutput("stall_req1_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    tick();
    checkOutput("pass_rsp1_valid", 32'(rsp1_valid), 32'd1);
    checkOutput("pass_result", rsp_result, 32'd42);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // Async reset in EXEC after a port-0 grant (last grant would favour port 1)
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_opsel = 5'b00001;
    tick();
    req0_valid = 1; req1_valid = 1;
    checkOutput("rst_in_exec_alu_a", alu_a, 32'd2);
    rst = 1;
    #1;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);
    #1;
    rst = 0;
    #1;
    checkOutput("post_rst_tie_req0", 32'(req0_ready), 32'd1);
    checkOutput("post_rst_tie_req1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    checkOutput("post_rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    tick();
    checkOutput("post_rst_rsp0", 32'(rsp0_valid), 32'd1);
    checkOutput("post_rst_result", rsp_result, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
